// File: rtl/ysyx_23060180_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_pkg
// Description : Shared encodings and widths for the core memory arbiter.
// Revision    : 1.0
// ============================================================================
package ysyx_23060180_pkg;

    localparam int unsigned c_XLEN   = 32;
    localparam int unsigned c_MASK_W = c_XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060180_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_mem_arbiter_if
// Description : IFU, LSU and downstream memory signals seen by the arbiter.
// Revision    : 1.0
// ============================================================================
interface ysyx_23060180_mem_arbiter_if;
    import ysyx_23060180_pkg::*;

    logic                ifu_req;
    logic [c_XLEN-1:0]   ifu_addr;
    logic                ifu_gnt;
    logic                ifu_rvalid;
    logic [c_XLEN-1:0]   ifu_rdata;
    logic                ifu_err;

    logic                lsu_req;
    logic                lsu_we;
    logic [c_XLEN-1:0]   lsu_addr;
    logic [c_XLEN-1:0]   lsu_wdata;
    logic [c_MASK_W-1:0] lsu_wmask;
    logic                lsu_gnt;
    logic                lsu_rvalid;
    logic [c_XLEN-1:0]   lsu_rdata;
    logic                lsu_err;

    logic                mem_req;
    logic                mem_we;
    logic [c_XLEN-1:0]   mem_addr;
    logic [c_XLEN-1:0]   mem_wdata;
    logic [c_MASK_W-1:0] mem_wmask;
    logic                mem_ready;
    logic                mem_rvalid;
    logic [c_XLEN-1:0]   mem_rdata;

    // master: the arbiter itself; slave: the fetch/LSU stages plus memory
    modport master (
        input  ifu_req, ifu_addr,
        output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        output ifu_req, ifu_addr,
        input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_23060180_mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_mem_arb_pick
// Description : LSU-priority pick with IFU anti-starvation override.
// Revision    : 1.0
// ============================================================================
module ysyx_23060180_mem_arb_pick
    import ysyx_23060180_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  wire logic          ifu_req,
    input  wire logic          lsu_req,
    input  wire logic [SW-1:0] starve_cnt,
    output logic      [1:0]    gnt
);

    always_comb begin
        gnt = 2'b00;
        if (ifu_req && lsu_req) begin
            if (starve_cnt == SW'(STARVE_LIMIT)) begin
                gnt[OWN_IFU] = 1'b1;
            end else begin
                gnt[OWN_LSU] = 1'b1;
            end
        end else if (lsu_req) begin
            gnt[OWN_LSU] = 1'b1;
        end else if (ifu_req) begin
            gnt[OWN_IFU] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060180_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_mem_arbiter
// Description : Single-outstanding IFU/LSU memory arbiter with timeout.
// Revision    : 1.0
// ============================================================================
module ysyx_23060180_mem_arbiter
    import ysyx_23060180_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 5
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    ysyx_23060180_mem_arbiter_if.master bus
);

    localparam int               c_SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    owner_e              r_owner;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [c_XLEN-1:0]   r_mem_addr;
    logic [c_XLEN-1:0]   r_mem_wdata;
    logic [c_MASK_W-1:0] r_mem_wmask;
    logic                r_ifu_rvalid;
    logic                r_lsu_rvalid;
    logic                r_ifu_err;
    logic                r_lsu_err;
    logic [c_XLEN-1:0]   r_ifu_rdata;
    logic [c_XLEN-1:0]   r_lsu_rdata;
    logic [CNT_W-1:0]    r_tmo_cnt;
    logic [c_SW-1:0]     r_starve_cnt;
    logic [1:0]          w_pick;
    logic [1:0]          w_gnt;
    logic                w_rsp;
    logic                w_tmo;
    logic                w_lsu_store;
    logic [c_XLEN-1:0]   w_rsp_rdata;

    ysyx_23060180_mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (c_SW)
    ) u_pick (
        .ifu_req    (bus.ifu_req),
        .lsu_req    (bus.lsu_req),
        .starve_cnt (r_starve_cnt),
        .gnt        (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A real response wins over a timeout landing in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 2'b00;
        w_rsp       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt = w_pick;
                if (|w_pick) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_ready && bus.mem_rvalid) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_rsp       = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (bus.mem_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_rsp       = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_lsu_store = w_gnt[OWN_LSU] & bus.lsu_we;
    assign w_rsp_rdata = (w_tmo || r_mem_we) ? '0 : bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_IFU;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_ifu_err    <= 1'b0;
            r_lsu_err    <= 1'b0;
            r_ifu_rdata  <= '0;
            r_lsu_rdata  <= '0;
            r_tmo_cnt    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_ifu_err    <= 1'b0;
            r_lsu_err    <= 1'b0;
            r_ifu_rdata  <= '0;
            r_lsu_rdata  <= '0;

            if (|w_gnt) begin
                r_owner     <= owner_e'(w_gnt[OWN_LSU]);
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_lsu_store;
                r_mem_addr  <= w_gnt[OWN_LSU] ? bus.lsu_addr : bus.ifu_addr;
                r_mem_wdata <= w_lsu_store ? bus.lsu_wdata : '0;
                r_mem_wmask <= w_lsu_store ? bus.lsu_wmask : '0;
                r_tmo_cnt   <= '0;
            end else if (r_state != ST_IDLE) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if ((r_state == ST_REQ && bus.mem_ready) || w_rsp) begin
                r_mem_req <= 1'b0;
            end

            if (w_rsp) begin
                if (r_owner == OWN_LSU) begin
                    r_lsu_rvalid <= 1'b1;
                    r_lsu_err    <= w_tmo;
                    r_lsu_rdata  <= w_rsp_rdata;
                end else begin
                    r_ifu_rvalid <= 1'b1;
                    r_ifu_err    <= w_tmo;
                    r_ifu_rdata  <= w_rsp_rdata;
                end
            end

            // Count only conflicts lost by IFU; saturate so the override sticks
            if (w_gnt[OWN_IFU]) begin
                r_starve_cnt <= '0;
            end else if (w_gnt[OWN_LSU] && bus.ifu_req &&
                         r_starve_cnt != c_SW'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign bus.ifu_gnt    = w_gnt[OWN_IFU];
    assign bus.lsu_gnt    = w_gnt[OWN_LSU];
    assign bus.ifu_rvalid = r_ifu_rvalid;
    assign bus.ifu_rdata  = r_ifu_rdata;
    assign bus.ifu_err    = r_ifu_err;
    assign bus.lsu_rvalid = r_lsu_rvalid;
    assign bus.lsu_rdata  = r_lsu_rdata;
    assign bus.lsu_err    = r_lsu_err;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wmask  = r_mem_wmask;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060180_mem_arbiter
// Description : Directed self-checking bench for the IFU/LSU memory arbiter.
// Revision    : 1.0
// ============================================================================
module tb_ysyx_23060180_mem_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    ysyx_23060180_mem_arbiter_if bus ();

    ysyx_23060180_mem_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT      (16),
        .CNT_W        (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.ifu_req    = 1'b0;
        bus.ifu_addr   = '0;
        bus.lsu_req    = 1'b0;
        bus.lsu_we     = 1'b0;
        bus.lsu_addr   = '0;
        bus.lsu_wdata  = '0;
        bus.lsu_wmask  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        step();
        step();

        // Reset state
        check("rst_mem_req",    32'(bus.mem_req),    32'd0);
        check("rst_mem_addr",   bus.mem_addr,        32'd0);
        check("rst_ifu_rvalid", 32'(bus.ifu_rvalid), 32'd0);
        check("rst_lsu_rvalid", 32'(bus.lsu_rvalid), 32'd0);
        check("rst_ifu_gnt",    32'(bus.ifu_gnt),    32'd0);
        rst = 1'b0;

        // IFU-only read, minimum latency
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 32'h8000_0000;
        #1;
        check("ifu_rd_gnt",     32'(bus.ifu_gnt), 32'd1);
        check("ifu_rd_lsu_gnt", 32'(bus.lsu_gnt), 32'd0);
        step();
        bus.ifu_req = 1'b0;
        check("ifu_rd_mem_req",  32'(bus.mem_req),   32'd1);
        check("ifu_rd_mem_addr", bus.mem_addr,       32'h8000_0000);
        check("ifu_rd_mem_we",   32'(bus.mem_we),    32'd0);
        check("ifu_rd_wmask",    32'(bus.mem_wmask), 32'd0);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        check("ifu_rd_wait_req", 32'(bus.mem_req), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0010_0073;
        step();
        bus.mem_rvalid = 1'b0;
        check("ifu_rd_rvalid",   32'(bus.ifu_rvalid), 32'd1);
        check("ifu_rd_rdata",    bus.ifu_rdata,       32'h0010_0073);
        check("ifu_rd_err",      32'(bus.ifu_err),    32'd0);
        check("ifu_rd_lsu_rv",   32'(bus.lsu_rvalid), 32'd0);
        step();
        check("ifu_rd_pulse_end", 32'(bus.ifu_rvalid), 32'd0);

        // LSU store, ready and rvalid together in REQ
        bus.lsu_req   = 1'b1;
        bus.lsu_we    = 1'b1;
        bus.lsu_addr  = 32'h8000_1000;
        bus.lsu_wdata = 32'hDEAD_BEEF;
        bus.lsu_wmask = 4'hF;
        #1;
        check("st_lsu_gnt", 32'(bus.lsu_gnt), 32'd1);
        check("st_ifu_gnt", 32'(bus.ifu_gnt), 32'd0);
        step();
        bus.lsu_req = 1'b0;
        check("st_mem_req",   32'(bus.mem_req),   32'd1);
        check("st_mem_we",    32'(bus.mem_we),    32'd1);
        check("st_mem_addr",  bus.mem_addr,       32'h8000_1000);
        check("st_mem_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
        check("st_mem_wmask", 32'(bus.mem_wmask), 32'hF);
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        step();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        check("st_lsu_rvalid", 32'(bus.lsu_rvalid), 32'd1);
        check("st_lsu_rdata",  bus.lsu_rdata,       32'd0);
        check("st_lsu_err",    32'(bus.lsu_err),    32'd0);
        check("st_ifu_rvalid", 32'(bus.ifu_rvalid), 32'd0);
        check("st_mem_req_lo", 32'(bus.mem_req),    32'd0);

        // Continuous conflict: LSU x4, IFU, LSU; back-to-back transfers
        bus.ifu_req    = 1'b1;
        bus.ifu_addr   = 32'h8000_0100;
        bus.lsu_req    = 1'b1;
        bus.lsu_we     = 1'b0;
        bus.lsu_addr   = 32'h8000_2000;
        bus.lsu_wmask  = 4'hF;
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_0001;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("stv_ifu_gnt", 32'(bus.ifu_gnt), (i == 4) ? 32'd1 : 32'd0);
            check("stv_lsu_gnt", 32'(bus.lsu_gnt), (i == 4) ? 32'd0 : 32'd1);
            if (i == 4) begin
                check("stv_cnt_sat", 32'(dut.r_starve_cnt), 32'd4);
            end
            step();
            check("stv_mem_addr",  bus.mem_addr, (i == 4) ? 32'h8000_0100 : 32'h8000_2000);
            check("stv_mem_wmask", 32'(bus.mem_wmask), 32'd0);
            if (i == 4) begin
                check("stv_cnt_clr", 32'(dut.r_starve_cnt), 32'd0);
            end
            if (i == 5) begin
                bus.ifu_req = 1'b0;
                bus.lsu_req = 1'b0;
            end
            step();
            check("stv_ifu_rvalid", 32'(bus.ifu_rvalid), (i == 4) ? 32'd1 : 32'd0);
            check("stv_lsu_rvalid", 32'(bus.lsu_rvalid), (i == 4) ? 32'd0 : 32'd1);
            if (i != 4) begin
                check("stv_lsu_rdata", bus.lsu_rdata, 32'hCAFE_0001);
            end
        end
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        step();
        check("stv_idle_rvalid", 32'(bus.lsu_rvalid), 32'd0);

        // mem_ready held low for three REQ cycles
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 32'h8000_0200;
        #1;
        check("stall_gnt", 32'(bus.ifu_gnt), 32'd1);
        step();
        bus.ifu_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("stall_mem_req",  32'(bus.mem_req), 32'd1);
            check("stall_mem_addr", bus.mem_addr,     32'h8000_0200);
            step();
        end
        bus.mem_ready = 1'b1;
        check("stall_req_still", 32'(bus.mem_req), 32'd1);
        step();
        bus.mem_ready = 1'b0;
        check("stall_wait_req", 32'(bus.mem_req), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        step();
        bus.mem_rvalid = 1'b0;
        check("stall_rvalid", 32'(bus.ifu_rvalid), 32'd1);
        check("stall_rdata",  bus.ifu_rdata,       32'h1111_2222);
        check("stall_err",    32'(bus.ifu_err),    32'd0);

        // Timeout: 16 cycles after entering REQ, then a stray mem_rvalid
        bus.lsu_req  = 1'b1;
        bus.lsu_we   = 1'b0;
        bus.lsu_addr = 32'h8000_3000;
        #1;
        check("tmo_gnt", 32'(bus.lsu_gnt), 32'd1);
        step();
        bus.lsu_req   = 1'b0;
        bus.mem_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            step();
            bus.mem_ready = 1'b0;
        end
        check("tmo_not_early", 32'(bus.lsu_rvalid), 32'd0);
        step();
        check("tmo_rvalid",   32'(bus.lsu_rvalid), 32'd1);
        check("tmo_err",      32'(bus.lsu_err),    32'd1);
        check("tmo_rdata",    bus.lsu_rdata,       32'd0);
        check("tmo_ifu_rv",   32'(bus.ifu_rvalid), 32'd0);
        check("tmo_mem_req",  32'(bus.mem_req),    32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_5555;
        step();
        bus.mem_rvalid = 1'b0;
        check("stray_lsu_rv", 32'(bus.lsu_rvalid), 32'd0);
        check("stray_ifu_rv", 32'(bus.ifu_rvalid), 32'd0);

        // Reset in WAIT abandons the transfer silently
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 32'h8000_0300;
        #1;
        check("rstw_gnt", 32'(bus.ifu_gnt), 32'd1);
        step();
        bus.ifu_req   = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw_mem_req",  32'(bus.mem_req),    32'd0);
        check("rstw_mem_addr", bus.mem_addr,        32'd0);
        check("rstw_mem_we",   32'(bus.mem_we),     32'd0);
        check("rstw_ifu_rv",   32'(bus.ifu_rvalid), 32'd0);
        check("rstw_lsu_rv",   32'(bus.lsu_rvalid), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_7777;
        step();
        bus.mem_rvalid = 1'b0;
        check("rstw_ignored", 32'(bus.ifu_rvalid), 32'd0);
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 32'h8000_0400;
        #1;
        check("rstw_new_gnt", 32'(bus.ifu_gnt), 32'd1);
        step();
        bus.ifu_req   = 1'b0;
        bus.mem_ready = 1'b1;
        check("rstw_new_addr", bus.mem_addr, 32'h8000_0400);
        step();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_F00D;
        step();
        bus.mem_rvalid = 1'b0;
        check("rstw_new_rvalid", 32'(bus.ifu_rvalid), 32'd1);
        check("rstw_new_rdata",  bus.ifu_rdata,       32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
